// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM ROM read arbiter: per-slot one-word tag/data buffers in front of a
// single SDRAM read channel, fixed-priority or round-robin grant.

module jtframe_rom_nslot_lane #(
  parameter int          AW     = 18,
  parameter bit          DW8    = 1'b0,
  parameter logic [21:0] OFFSET = '0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_wa,
  input  logic [15:0]   fill_data,
  output logic          pend,
  output logic [AW-1:0] wa,
  output logic [21:0]   sa,
  output logic          ok,
  output logic [15:0]   dout
);
  logic [AW-1:0] tag;
  logic [15:0]   data;
  logic          valid;
  logic          hit;
  logic [15:0]   sel_data;

  // 8-bit slots address bytes; the buffer always holds one 16-bit SDRAM word
  assign wa   = DW8 ? (addr >> 1) : addr;
  assign sa   = OFFSET + 22'(wa);
  assign hit  = cs & valid & (tag == wa);
  assign pend = cs & ~hit;

  always_comb begin
    sel_data = data;
    if (DW8) sel_data = {8'd0, addr[0] ? data[15:8] : data[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
      ok    <= 1'b0;
      dout  <= '0;
    end else begin
      ok   <= hit & ~downloading;
      dout <= sel_data;
      if (downloading) begin
        valid <= 1'b0;
      end else if (fill) begin
        tag   <= fill_wa;
        data  <= fill_data;
        valid <= 1'b1;
      end
    end
  end
endmodule

module jtframe_rom_nslot #(
  parameter int                  SLOTS   = 4,
  parameter int                  AW      = 18,
  parameter logic [SLOTS-1:0]    DW8     = '0,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0,
  parameter int                  RR      = 0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      downloading,
  input  logic [SLOTS-1:0]          slot_cs,
  input  logic [SLOTS-1:0][AW-1:0]  slot_addr,
  output logic [SLOTS-1:0]          slot_ok,
  output logic [SLOTS-1:0][15:0]    slot_dout,
  output logic                      sdram_rd,
  output logic [21:0]               sdram_addr,
  input  logic                      sdram_ack,
  input  logic                      data_rdy,
  input  logic [15:0]               data_read
);
  localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] { IDLE, WAIT_ACK, WAIT_DATA } state_t;

  typedef struct packed {
    logic [IW-1:0] slot;
    logic [AW-1:0] wa;
  } req_t;

  state_t                   state, state_nx;
  req_t                     req, req_nx;
  logic [IW-1:0]            ptr, ptr_nx;
  logic [IW-1:0]            win;
  logic                     found;
  logic                     rd_nx;
  logic [21:0]              addr_nx;
  logic                     fill;
  logic [SLOTS-1:0]         pend;
  logic [SLOTS-1:0][AW-1:0] wa_all;
  logic [SLOTS-1:0][21:0]   sa_all;

  genvar i;
  generate
    for (i = 0; i < SLOTS; i++) begin : g_lane
      jtframe_rom_nslot_lane #(
        .AW     (AW),
        .DW8    (DW8[i]),
        .OFFSET (OFFSETS[i*22 +: 22])
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .cs          (slot_cs[i]),
        .addr        (slot_addr[i]),
        .fill        (fill && (req.slot == IW'(i))),
        .fill_wa     (req.wa),
        .fill_data   (data_read),
        .pend        (pend[i]),
        .wa          (wa_all[i]),
        .sa          (sa_all[i]),
        .ok          (slot_ok[i]),
        .dout        (slot_dout[i])
      );
    end
  endgenerate

  // Winner selection: highest pending index, or first pending at/after ptr
  always_comb begin
    int j;
    win   = '0;
    found = 1'b0;
    j     = 0;
    if (RR == 0) begin
      for (int k = 0; k < SLOTS; k++)
        if (pend[IW'(k)]) begin
          win   = IW'(k);
          found = 1'b1;
        end
    end else begin
      for (int k = 0; k < SLOTS; k++) begin
        j = int'(ptr) + k;
        if (j >= SLOTS) j = j - SLOTS;
        if (!found && pend[IW'(j)]) begin
          win   = IW'(j);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = req;
    ptr_nx   = ptr;
    rd_nx    = sdram_rd;
    addr_nx  = sdram_addr;
    fill     = 1'b0;
    if (downloading) begin
      state_nx = IDLE;
      rd_nx    = 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          rd_nx       = 1'b1;
          addr_nx     = sa_all[win];
          req_nx.slot = win;
          req_nx.wa   = wa_all[win];
          state_nx    = WAIT_ACK;
          if (RR != 0 && SLOTS > 1)
            ptr_nx = (win == IW'(SLOTS-1)) ? '0 : win + 1'b1;
        end
        WAIT_ACK: if (sdram_ack) begin
          rd_nx    = 1'b0;
          state_nx = WAIT_DATA;
        end
        WAIT_DATA: if (data_rdy) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req        <= '0;
      ptr        <= '0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nx;
      req        <= req_nx;
      ptr        <= ptr_nx;
      sdram_rd   <= rd_nx;
      sdram_addr <= addr_nx;
    end
  end
endmodule

// File: tb/tb_jtframe_rom_nslot.sv
// Bench for jtframe_rom_nslot: fixed-priority and round-robin instances share the
// slot stimulus; each has its own SDRAM responder and a transaction-level model.
module tb_jtframe_rom_nslot;
  localparam logic [3:0]  DW8B = 4'b0010;
  localparam logic [87:0] OFFS = {22'h020000, 22'h3FFFFF, 22'h000000, 22'h001000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic downloading = 1'b0;
  logic [3:0]        cs = '0;
  logic [3:0][17:0]  addr = '0;
  logic [1:0]        ok_v [0:1];
  logic [1:0][3:0]   ok;
  logic [1:0][3:0][15:0] dout;
  logic [1:0]        sd_rd;
  logic [1:0][21:0]  sd_addr;
  logic [1:0]        ack = '0, rdy = '0;
  logic [1:0][15:0]  rdata = '0;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtframe_rom_nslot #(.SLOTS(4), .AW(18), .DW8(DW8B), .OFFSETS(OFFS), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr(addr),
    .slot_ok(ok[0]), .slot_dout(dout[0]), .sdram_rd(sd_rd[0]), .sdram_addr(sd_addr[0]),
    .sdram_ack(ack[0]), .data_rdy(rdy[0]), .data_read(rdata[0]));

  jtframe_rom_nslot #(.SLOTS(4), .AW(18), .DW8(DW8B), .OFFSETS(OFFS), .RR(1)) dut1 (
    .clk(clk), .rst(rst), .downloading(downloading), .slot_cs(cs), .slot_addr(addr),
    .slot_ok(ok[1]), .slot_dout(dout[1]), .sdram_rd(sd_rd[1]), .sdram_addr(sd_addr[1]),
    .sdram_ack(ack[1]), .data_rdy(rdy[1]), .data_read(rdata[1]));

  function automatic logic [15:0] fdata(input logic [21:0] a);
    if (a == 22'h001010) return 16'hBEEF;
    if (a == 22'h000010) return 16'h12AB;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [17:0] waddr(input int i, input logic [17:0] a);
    return DW8B[i] ? (a >> 1) : a;
  endfunction

  function automatic logic [15:0] outsel(input int i, input logic [17:0] a, input logic [15:0] w);
    if (DW8B[i]) return {8'h00, a[0] ? w[15:8] : w[7:0]};
    return w;
  endfunction

  function automatic logic [21:0] sdaddr(input int i, input logic [17:0] a);
    int s;
    s = (int'(OFFS[i*22 +: 22]) + int'(waddr(i, a))) % 4194304;
    return s[21:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SDRAM responder: ack one cycle after a request, data four cycles after ack
  int          rcnt [2] = '{0, 0};
  logic [21:0] rcap [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ack[d] <= 1'b0;
      rdy[d] <= 1'b0;
      if (rcnt[d] == 0) begin
        if (sd_rd[d] && !ack[d]) begin
          ack[d]  <= 1'b1;
          rcnt[d] <= 4;
          rcap[d] <= sd_addr[d];
        end
      end else begin
        rcnt[d] <= rcnt[d] - 1;
        if (rcnt[d] == 1) begin
          rdy[d]   <= 1'b1;
          rdata[d] <= fdata(rcap[d]);
        end
      end
    end
  end

  // Transaction-level model: buffers, one outstanding access, grant rule per mode
  logic        m_rd   [2] = '{1'b0, 1'b0};
  logic [21:0] m_addr [2];
  logic [3:0]  m_ok   [2] = '{4'h0, 4'h0};
  logic [15:0] m_dout [2][4];
  logic        m_v    [2][4];
  logic [17:0] m_tag  [2][4];
  logic [15:0] m_data [2][4];
  int          m_ph   [2] = '{0, 0};
  int          m_win  [2];
  logic [17:0] m_wa   [2];
  int          m_ptr  [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_rd[d] <= 1'b0; m_ok[d] <= '0; m_ph[d] <= 0; m_ptr[d] <= 0;
        for (int i = 0; i < 4; i++) m_v[d][i] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] pend;
        logic       hit;
        int         w, j;
        for (int i = 0; i < 4; i++) begin
          hit = cs[i] && m_v[d][i] && (m_tag[d][i] == waddr(i, addr[i]));
          pend[i] = cs[i] && !hit;
          m_ok[d][i] <= hit && !downloading;
          if (hit) m_dout[d][i] <= outsel(i, addr[i], m_data[d][i]);
        end
        if (downloading) begin
          m_ph[d] <= 0;
          m_rd[d] <= 1'b0;
          for (int i = 0; i < 4; i++) m_v[d][i] <= 1'b0;
        end else if (m_ph[d] == 0) begin
          w = -1;
          if (d == 0) begin
            for (int i = 0; i < 4; i++) if (pend[i]) w = i;
          end else begin
            for (int k = 0; k < 4; k++) begin
              j = (m_ptr[d] + k) % 4;
              if (w < 0 && pend[j]) w = j;
            end
          end
          if (w >= 0) begin
            m_rd[d]   <= 1'b1;
            m_addr[d] <= sdaddr(w, addr[w]);
            m_wa[d]   <= waddr(w, addr[w]);
            m_win[d]  <= w;
            m_ph[d]   <= 1;
            if (d == 1) m_ptr[d] <= (w + 1) % 4;
          end
        end else if (m_ph[d] == 1) begin
          if (ack[d]) begin m_rd[d] <= 1'b0; m_ph[d] <= 2; end
        end else if (rdy[d]) begin
          m_v[d][m_win[d]]    <= 1'b1;
          m_tag[d][m_win[d]]  <= m_wa[d];
          m_data[d][m_win[d]] <= fdata(m_addr[d]);
          m_ph[d]             <= 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus a log of issued addresses
  logic [21:0] glog0[$], glog1[$];
  logic [1:0]  rd_prev = '0;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sd_rd[d] && !rd_prev[d]) begin
        if (d == 0) glog0.push_back(sd_addr[d]);
        else        glog1.push_back(sd_addr[d]);
      end
      chk($sformatf("model rd dut%0d", d), 32'(sd_rd[d]), 32'(m_rd[d]));
      if (m_rd[d]) chk($sformatf("model addr dut%0d", d), 32'(sd_addr[d]), 32'(m_addr[d]));
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model ok dut%0d slot%0d", d, i), 32'(ok[d][i]), 32'(m_ok[d][i]));
        if (m_ok[d][i])
          chk($sformatf("model dout dut%0d slot%0d", d, i), 32'(dout[d][i]), 32'(m_dout[d][i]));
      end
    end
    rd_prev <= sd_rd;
  end

  task automatic wait_ok(input logic [3:0] m, input string nm);
    int n = 0;
    while (!(((ok[0] & m) == m) && ((ok[1] & m) == m)) && n < 200) begin
      @(negedge clk); n++;
    end
    n_tests++;
    if (n >= 200) begin n_fail++; $display("FAIL %s: slot_ok never reached %b", nm, m); end
  endtask

  task automatic wait_rd(input int d, input string nm);
    int n = 0;
    while (!sd_rd[d] && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (n >= 200) begin n_fail++; $display("FAIL %s: sdram_rd never rose", nm); end
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset rd", 32'(sd_rd[d]), 0);
      chk("reset addr", 32'(sd_addr[d]), 0);
      chk("reset ok", 32'(ok[d]), 0);
      for (int i = 0; i < 4; i++) chk("reset dout", 32'(dout[d][i]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 16-bit slot with offset
    cs = 4'b0001; addr[0] = 18'h00010;
    @(negedge clk);
    wait_rd(0, "A rd");
    chk("A sdram_addr", 32'(sd_addr[0]), 32'h001010);
    wait_ok(4'b0001, "A ok");
    chk("A dout", 32'(dout[0][0]), 32'hBEEF);
    chk("A dout rr", 32'(dout[1][0]), 32'hBEEF);
    cs = '0;
    repeat (2) @(negedge clk);

    // 8-bit slot: odd byte fetch, then even byte from the buffer
    cs = 4'b0010; addr[1] = 18'h00021;
    @(negedge clk);
    wait_ok(4'b0010, "B ok");
    chk("B dout hi", 32'(dout[0][1]), 32'h0012);
    addr[1] = 18'h00020;
    @(negedge clk);
    chk("B ok lo", 32'(ok[0][1]), 1);
    chk("B dout lo", 32'(dout[0][1]), 32'h00AB);
    seen = 0;
    repeat (5) begin @(negedge clk); if (sd_rd != 0) seen++; end
    chk("B no refetch", seen, 0);
    cs = '0;
    repeat (2) @(negedge clk);

    // Three slots missing together
    glog0.delete(); glog1.delete();
    cs = 4'b1101; addr[0] = 18'h20; addr[2] = 18'h5; addr[3] = 18'h7;
    @(negedge clk);
    wait_ok(4'b1101, "C ok");
    chk("C n dut0", glog0.size(), 3);
    chk("C n dut1", glog1.size(), 3);
    if (glog0.size() == 3 && glog1.size() == 3) begin
      chk("C fp 1st", 32'(glog0[0]), 32'h020007);
      chk("C fp 2nd", 32'(glog0[1]), 32'h000004);
      chk("C fp 3rd", 32'(glog0[2]), 32'h001020);
      chk("C rr 1st", 32'(glog1[0]), 32'h000004);
      chk("C rr 2nd", 32'(glog1[1]), 32'h020007);
      chk("C rr 3rd", 32'(glog1[2]), 32'h001020);
    end
    chk("C dout3", 32'(dout[0][3]), 32'hA5C4);
    cs = '0;
    repeat (2) @(negedge clk);

    // Slots 1 and 3 re-missing every cycle
    glog0.delete(); glog1.delete();
    cs = 4'b1010; addr[1] = 18'h100; addr[3] = 18'h200;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      addr[1] = addr[1] + 18'd2;
      addr[3] = addr[3] + 18'd1;
    end
    cs = '0;
    chk("D rr grants>=4", 32'(glog1.size() >= 4), 1);
    if (glog1.size() >= 4) begin
      chk("D rr g0 slot1", 32'(glog1[0] < 22'h020000), 1);
      chk("D rr g1 slot3", 32'(glog1[1] >= 22'h020000), 1);
      chk("D rr g2 slot1", 32'(glog1[2] < 22'h020000), 1);
      chk("D rr g3 slot3", 32'(glog1[3] >= 22'h020000), 1);
    end
    seen = 0;
    foreach (glog0[k]) if (glog0[k] < 22'h020000) seen++;
    chk("D fp only slot3", seen, 0);
    repeat (12) @(negedge clk);

    // Download pulse while waiting for data
    cs = 4'b0101; addr[0] = 18'h30; addr[2] = 18'h5;
    @(negedge clk);
    wait_rd(0, "E rd");
    repeat (2) @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    chk("E dl rd", 32'(sd_rd), 0);
    chk("E dl ok0", 32'(ok[0]), 0);
    chk("E dl ok1", 32'(ok[1]), 0);
    @(negedge clk);
    downloading = 1'b0;
    wait_ok(4'b0101, "E refill");
    chk("E dout0", 32'(dout[0][0]), 32'hB5F3);
    chk("E dout2", 32'(dout[1][2]), 32'hA5C7);
    cs = '0;
    repeat (2) @(negedge clk);

    // SDRAM address wrap
    cs = 4'b0100; addr[2] = 18'h2;
    @(negedge clk);
    wait_rd(0, "F rd");
    chk("F wrap dut0", 32'(sd_addr[0]), 32'h000001);
    chk("F wrap dut1", 32'(sd_addr[1]), 32'h000001);
    wait_ok(4'b0100, "F ok");
    chk("F dout", 32'(dout[0][2]), 32'hA5C2);
    cs = '0;
    repeat (2) @(negedge clk);

    // Reset while waiting for ack
    cs = 4'b1000; addr[3] = 18'h100;
    @(negedge clk);
    wait_rd(0, "R rd");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("R async rd", 32'(sd_rd), 0);
    chk("R async addr", 32'(sd_addr[0]), 0);
    chk("R async ok", 32'({ok[1], ok[0]}), 0);
    @(negedge clk);
    cs = '0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cs = 4'b1000;
    @(negedge clk);
    chk("R no fill ok", 32'(ok[0][3]), 0);
    chk("R re-request", 32'(sd_rd[0]), 1);
    wait_ok(4'b1000, "R ok");
    chk("R dout", 32'(dout[0][3]), 32'hA4C3);
    cs = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/jtframe_rom_nslot.md
Name: jtframe_rom_nslot

Overview:
- Parametrised N-slot SDRAM ROM read arbiter for jtframe game cores.
- Replaces the fixed 9-slot ROM arbiter and generalises slot count, per-slot data width, per-slot SDRAM offset and the arbitration mode.
- Each slot keeps a one-word tag/data buffer, so repeated reads of the same SDRAM word return data without an SDRAM access.
- Sits between CPU/video/sound ROM requesters and the SDRAM controller's single read channel.

Parameters:
- SLOTS, 4: number of requester slots (1..16).
- AW, 18: slot address width in bus units; unused upper bits of narrower slots are tied to 0 by the user.
- DW8, 4'b0000: bit i=1 makes slot i an 8-bit slot; otherwise it is a 16-bit slot.
- OFFSETS, 0: flat vector of SLOTS×22 bits; field i is slot i's 16-bit-word SDRAM offset.
- RR, 0: arbitration mode. 0 = fixed priority, highest index wins. 1 = round-robin.

Ports:
- clk  in  1  system clock; SDRAM side and all slots share it.
- rst  in  1  asynchronous reset, active-high.
- downloading  in  1  ROM download in progress.
- slot_cs  in  SLOTS  per-slot read request.
- slot_addr  in  SLOTS×AW  per-slot address. Word address for 16-bit slots; byte address for 8-bit slots.
- slot_ok  out  SLOTS  slot_dout valid for the current slot_addr.
- slot_dout  out  SLOTS×16  per-slot data. 8-bit slots use bits [7:0]; bits [15:8] are 0.
- sdram_rd  out  1  read request to SDRAM.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  request accepted.
- data_rdy  in  1  data_read valid.
- data_read  in  16  SDRAM data.

Behaviour:
- Reset state: all outputs 0; all tags invalid; state IDLE; round-robin pointer at 0.
- Word address per slot: wa_i = slot_addr_i for 16-bit slots, slot_addr_i>>1 for 8-bit slots. SDRAM address = OFFSETS_i + wa_i, modulo 2^22 (wrap, no saturation).
- Hit: slot_cs_i & valid_i & (tag_i == wa_i).
  - slot_ok_i is registered and equals the hit term of the previous cycle.
  - slot_dout_i is registered. 8-bit slots select data[15:8] when slot_addr_i[0]=1, else data[7:0].
  - Latency on a hit is 1 cycle.
- If cs drops or the address changes, slot_ok falls on the next edge.
- Miss: slot_cs_i & ~hit_i makes slot i pending.
- State machine:
  - IDLE: when any slot is pending and downloading=0, select a winner, latch sdram_addr, set sdram_rd=1 and go to WAIT_ACK.
    - RR=0: highest pending index wins.
    - RR=1: first pending index at or after the pointer, modulo SLOTS, wins; the pointer then moves to winner+1 (modulo SLOTS).
  - WAIT_ACK: on sdram_ack, drop sdram_rd and go to WAIT_DATA.
  - WAIT_DATA: on data_rdy, write tag_w=latched wa, data_w=data_read, valid_w=1, and go to IDLE. slot_ok_w rises on the following edge if cs and addr are unchanged.
- If the winner's address changed during the access, its buffer is still filled with the old word. The new address misses and is re-requested.
- Only one access is in flight at a time. Requests arriving during an access wait.
- sdram_ack together with data_rdy in the same cycle: ack is taken and data is captured in WAIT_DATA on the next data_rdy only.
- downloading=1, in any state:
  - next edge: state IDLE, sdram_rd=0, all valid cleared, all slot_ok=0;
  - no requests are issued while downloading stays high;
  - any in-flight data is discarded.
- rst asserted mid-access: immediate return to the reset state; a later data_rdy while IDLE is ignored.
- SLOTS=1: no arbitration; the RR pointer stays 0.

Test Plan:
- SLOTS=4, slot0 16-bit with OFFSET 0x1000, addr 0x00010, cs=1 → sdram_rd=1, sdram_addr=0x001010; after ack and data_rdy with 0xBEEF, slot_ok0=1 and slot_dout0=0xBEEF one cycle later.
- Slot1 8-bit with OFFSET 0: read addr 0x0021 (data 0x12AB), then switch to 0x0020 → the second read gives slot_ok1=1 and dout=0x00AB one cycle after the change, with no new sdram_rd.
- RR=0, slots 0, 2 and 3 all missing → serviced in order 3, 2, 0, confirmed by three sequential sdram_addr values.
- RR=1, slots 1 and 3 continuously re-missing via changing addresses → grants alternate 1, 3, 1, 3.
- downloading pulsed high during WAIT_DATA → sdram_rd=0 and every slot_ok=0 next edge; the stale data_rdy is ignored; after downloading falls, the miss is re-requested and completes.
- OFFSET 0x3FFFFF with addr 2 → sdram_addr=0x000001; rst asserted in WAIT_ACK → outputs 0 asynchronously and no fill occurs.
